// File: rtl/jpeg2bmp_qdiv_16s_16u_16_seq.sv
// rtl/jpeg2bmp_qdiv_16s_16u_16_seq.sv - sequential signed/unsigned quantizing divider
module jpeg2bmp_qdiv_16s_16u_16_seq #(
  parameter int ROUND = 1,
  parameter int DW    = 16
) (
  input  logic          ap_clk,
  input  logic          ap_rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] din0,
  input  logic [DW-1:0] din1,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] dout,
  output logic          div_by_zero
);

  localparam int CW = $clog2(DW);
  localparam logic [DW-1:0] ONE     = {{(DW-1){1'b0}}, 1'b1};
  localparam logic [DW-1:0] SAT_POS = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] SAT_NEG = {1'b1, {(DW-1){1'b0}}};

  // LOAD is the output register stage between FIX and DONE.
  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_LOAD,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic [DW-1:0] mag;    // dividend magnitude, shifted left one bit per iteration
  logic          neg;    // captured sign of the dividend
  logic [DW-1:0] dvsr;
  logic          dbz;
  logic [DW:0]   rem;    // one bit wider than the divisor so the shift cannot overflow
  logic [DW-1:0] quo;
  logic [CW-1:0] cnt;
  logic [DW-1:0] res;

  logic [DW:0]   rem_sh;
  logic          rem_ge;
  logic [DW:0]   rem_sub;
  logic          rnd_up;
  logic [DW-1:0] q_rnd;
  logic [DW-1:0] q_fix;
  logic [DW-1:0] din0_abs;

  // State register.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state selection; a zero divisor still walks CALC so latency is unchanged.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (in_valid) state_nx = S_CALC;
      S_CALC:  if (cnt == '0) state_nx = S_FIX;
      S_FIX:   state_nx = S_LOAD;
      S_LOAD:  state_nx = S_DONE;
      S_DONE:  if (out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state.
  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_DONE);
  end

  // One restoring step, rounding and sign application.
  always_comb begin
    din0_abs = din0[DW-1] ? ((~din0) + ONE) : din0;
    rem_sh   = {rem[DW-1:0], mag[DW-1]};
    rem_ge   = (rem_sh >= {1'b0, dvsr});
    rem_sub  = rem_sh - {1'b0, dvsr};
    rnd_up   = (ROUND != 0) && ({rem, 1'b0} >= {2'b00, dvsr});
    q_rnd    = quo + {{(DW-1){1'b0}}, rnd_up};
    if (dbz) begin
      q_fix = neg ? SAT_NEG : SAT_POS;
    end else if (neg) begin
      q_fix = (~q_rnd) + ONE;
    end else begin
      q_fix = q_rnd;
    end
  end

  // Operand capture and quotient iteration.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      mag  <= '0;
      neg  <= 1'b0;
      dvsr <= '0;
      dbz  <= 1'b0;
      rem  <= '0;
      quo  <= '0;
      cnt  <= '0;
      res  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            mag  <= din0_abs;
            neg  <= din0[DW-1];
            dvsr <= din1;
            dbz  <= (din1 == '0);
            rem  <= '0;
            quo  <= '0;
            cnt  <= CW'(DW - 1);
          end
        end
        S_CALC: begin
          cnt <= cnt - 1'b1;
          if (!dbz) begin
            mag <= {mag[DW-2:0], 1'b0};
            if (rem_ge) begin
              rem <= rem_sub;
              quo <= {quo[DW-2:0], 1'b1};
            end else begin
              rem <= rem_sh;
              quo <= {quo[DW-2:0], 1'b0};
            end
          end
        end
        S_FIX: begin
          res <= q_fix;
        end
        default: begin
        end
      endcase
    end
  end

  // Result register; dout keeps its last value once the result is taken.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      dout        <= '0;
      div_by_zero <= 1'b0;
    end else if (state == S_LOAD) begin
      dout        <= res;
      div_by_zero <= dbz;
    end
  end

endmodule

// File: tb/tb_jpeg2bmp_qdiv_16s_16u_16_seq.sv
// tb/tb_jpeg2bmp_qdiv_16s_16u_16_seq.sv - scoreboard bench for the quantizing divider
module tb_jpeg2bmp_qdiv_16s_16u_16_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] din0 = '0;
  logic [15:0] din1 = '0;
  logic        out_ready = 1'b1;
  logic        in_ready1, out_valid1, dbz1;
  logic        in_ready0, out_valid0, dbz0;
  logic [15:0] dout1, dout0;

  jpeg2bmp_qdiv_16s_16u_16_seq #(.ROUND(1), .DW(16)) u_r1 (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .din0(din0), .din1(din1), .out_valid(out_valid1), .out_ready(out_ready),
    .dout(dout1), .div_by_zero(dbz1)
  );

  jpeg2bmp_qdiv_16s_16u_16_seq #(.ROUND(0), .DW(16)) u_r0 (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .din0(din0), .din1(din1), .out_valid(out_valid0), .out_ready(out_ready),
    .dout(dout0), .div_by_zero(dbz0)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [15:0] d1;
    logic [15:0] d0;
    logic        dz;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  task automatic issue(input int a, input int b, input int e1, input int e0,
                       input bit dz, input bit track);
    int t;
    exp_t e;
    t = 0;
    @(negedge clk);
    while (!in_ready1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready1) begin
      chk("in_ready_timeout", 32'd0, 32'd1);
      return;
    end
    din0     = a[15:0];
    din1     = b[15:0];
    in_valid = 1'b1;
    if (track) begin
      e.d1 = e1[15:0];
      e.d0 = e0[15:0];
      e.dz = dz;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (track) acc_q.push_back(cyc);
    in_valid = 1'b0;
  endtask

  // Monitor: compares every presented result against the scoreboard head.
  bit seen = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        seen = 1'b0;
      end else begin
        if (out_valid1 || out_valid0) begin
          chk("valid_pair", {31'd0, out_valid0}, {31'd0, out_valid1});
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_valid: got out_valid=1 expected none pending (cycle %0d)", cyc);
          end else begin
            if (!seen) begin
              seen = 1'b1;
              if (acc_q.size() != 0) chk("latency", cyc - acc_q.pop_front(), 32'd18);
            end
            chk("dout_round1", {16'd0, dout1}, {16'd0, exp_q[0].d1});
            chk("dout_round0", {16'd0, dout0}, {16'd0, exp_q[0].d0});
            chk("dbz_round1", {31'd0, dbz1}, {31'd0, exp_q[0].dz});
            chk("dbz_round0", {31'd0, dbz0}, {31'd0, exp_q[0].dz});
            chk("in_ready_busy", {31'd0, in_ready1}, 32'd0);
            if (out_ready) begin
              void'(exp_q.pop_front());
              seen = 1'b0;
            end
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  int va[13]  = '{100, -100, 24, -24, -32768, 32767, -32768, 5, -5, 0, 7, -7, 1000};
  int vb[13]  = '{16, 16, 16, 16, 1, 65535, 65535, 0, 0, 5, 2, 2, 7};
  int ve1[13] = '{6, -6, 2, -2, -32768, 0, -1, 32767, -32768, 0, 4, -4, 143};
  int ve0[13] = '{6, -6, 1, -1, -32768, 0, 0, 32767, -32768, 0, 3, -3, 142};
  bit vdz[13] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0};

  initial begin
    int t;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready1}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid1}, 32'd0);
    chk("rst_dout", {16'd0, dout1}, 32'd0);
    chk("rst_dbz", {31'd0, dbz1}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      issue(va[i], vb[i], ve1[i], ve0[i], vdz[i], 1'b1);
    end

    // Backpressure: result must hold while extra in_valid pulses are ignored.
    issue(1000, 3, 333, 333, 1'b0, 1'b1);
    out_ready = 1'b0;
    t = 0;
    while (!out_valid1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("bp_valid_seen", {31'd0, out_valid1}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = i[0];
      din0     = 16'd999;
      din1     = 16'd1;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("bp_release_in_ready", {31'd0, in_ready1}, 32'd1);
    chk("bp_release_valid", {31'd0, out_valid1}, 32'd0);
    chk("bp_dout_hold", {16'd0, dout1}, 32'd333);

    // Reset in the middle of an operation.
    issue(1000, 7, 0, 0, 1'b0, 1'b0);
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", {31'd0, in_ready1}, 32'd1);
    chk("midrst_out_valid", {31'd0, out_valid1}, 32'd0);
    chk("midrst_dout", {16'd0, dout1}, 32'd0);
    chk("midrst_dbz", {31'd0, dbz1}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    issue(1000, 7, 143, 142, 1'b0, 1'b1);

    t = 0;
    while (exp_q.size() != 0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk("drain_pending", exp_q.size(), 32'd0);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
